// File: rtl/tejas_pkg.sv
// Shared definitions for the TEJAS register file: default sizes and the clear FSM state encoding.
package tejas_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_bypass_mux.sv
// Per-read-port output select: array word, optional same-cycle write forwarding, x0 and not-ready forcing.
module rf_bypass_mux
    import tejas_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int AW       = 5,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              valid,
    input  logic [AW-1:0]     rd_addr,
    input  logic [XLEN-1:0]   arr_word,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    output logic [XLEN-1:0]   rd_word
);

    always_comb begin
        rd_word = arr_word;
        // Ascending scan so the highest-index matching port has the last word.
        if (BYPASS != 0) begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_addr[k*AW +: AW] == rd_addr)) begin
                    rd_word = wr_data[k*XLEN +: XLEN];
                end
            end
        end
        if (!valid || ((ZERO_REG != 0) && (rd_addr == '0))) begin
            rd_word = '0;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with post-reset / on-demand clear sweep and optional write bypass.
module reg_file_mp
    import tejas_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear_req,
    output logic                ready,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data
);

    rf_state_e       state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic            ready_q, ready_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NWR-1:0]  wr_en_eff;

    assign ready     = ready_q;
    assign wr_en_eff = ready_q ? wr_en : '0;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        case (state_q)
            RF_CLEAR: begin
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(NREGS - 1)) begin
                    state_d = RF_READY;
                    ready_d = 1'b1;
                end
            end
            RF_READY: begin
                if (clear_req) begin
                    state_d   = RF_CLEAR;
                    clr_idx_d = '0;
                    ready_d   = 1'b0;
                end
            end
            default: begin
                state_d   = RF_CLEAR;
                clr_idx_d = '0;
                ready_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (state_q == RF_CLEAR) begin
            regs_d[clr_idx_q] = '0;
        end
        // Later ports overwrite earlier ones on an address collision.
        for (int k = 0; k < NWR; k++) begin
            if (wr_en_eff[k] && !((ZERO_REG != 0) && (wr_addr[k*AW +: AW] == '0))) begin
                regs_d[wr_addr[k*AW +: AW]] = wr_data[k*XLEN +: XLEN];
            end
        end
    end

    // Storage has no reset so it can map onto RAM; the sweep provides the zeroing.
    always_ff @(posedge clock) begin
        regs_q <= regs_d;
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        rf_bypass_mux #(
            .XLEN     (XLEN),
            .AW       (AW),
            .NWR      (NWR),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_mux (
            .valid    (ready_q),
            .rd_addr  (rd_addr[r*AW +: AW]),
            .arr_word (regs_q[rd_addr[r*AW +: AW]]),
            .wr_en    (wr_en_eff),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_word  (rd_data[r*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench: dut_a is dual-write/dual-read with bypass and hardwired x0; dut_b is single-port, no bypass, x0 ordinary.
module tb_reg_file_mp;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        clear_req_a = 1'b0;
    logic        ready_a;
    logic [1:0]  wr_en_a = '0;
    logic [9:0]  wr_addr_a = '0;
    logic [63:0] wr_data_a = '0;
    logic [9:0]  rd_addr_a = '0;
    logic [63:0] rd_data_a;

    logic        clear_req_b = 1'b0;
    logic        ready_b;
    logic [0:0]  wr_en_b = '0;
    logic [4:0]  wr_addr_b = '0;
    logic [31:0] wr_data_b = '0;
    logic [4:0]  rd_addr_b = '0;
    logic [31:0] rd_data_b;

    int checks = 0;
    int passes = 0;
    int na, nb;

    always #5 clock = ~clock;

    reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clock(clock), .reset(reset), .clear_req(clear_req_a), .ready(ready_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a)
    );

    reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(1), .NWR(1), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clock(clock), .reset(reset), .clear_req(clear_req_b), .ready(ready_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b)
    );

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Counts edges until each DUT raises ready; optionally pulses clear_req_a mid-sweep.
    task automatic wait_both(output int ca, output int cb, input bit pulse_clr);
        ca = -1;
        cb = -1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            clear_req_a = (pulse_clr && c == 5);
            if (ca < 0 && ready_a) ca = c;
            if (cb < 0 && ready_b) cb = c;
            if (ca >= 0 && cb >= 0) break;
        end
        clear_req_a = 1'b0;
    endtask

    initial begin
        // Reset held for 3 cycles
        rd_addr_a = {5'd5, 5'd5};
        rd_addr_b = 5'd5;
        tick(); tick(); tick();
        chk("reset_ready_a", 64'(ready_a), 64'd0);
        chk("reset_ready_b", 64'(ready_b), 64'd0);
        chk("reset_rd_a", rd_data_a, 64'd0);
        reset = 1'b0;
        wait_both(na, nb, 1'b0);
        chk("sweep_len_a", 64'(na), 64'd32);
        chk("sweep_len_b", 64'(nb), 64'd32);

        for (int i = 0; i < 32; i++) begin
            rd_addr_a = {5'(31 - i), 5'(i)};
            rd_addr_b = 5'(i);
            #1;
            chk("swept_a0", rd_data_a[31:0], 64'd0);
            chk("swept_a1", rd_data_a[63:32], 64'd0);
            chk("swept_b", 64'(rd_data_b), 64'd0);
        end

        // x5 write: bypass visible same cycle on A, only next cycle on B
        wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd5}; wr_data_a = {32'd0, 32'hDEADBEEF};
        rd_addr_a = {5'd5, 5'd1};
        wr_en_b = 1'b1; wr_addr_b = 5'd5; wr_data_b = 32'hDEADBEEF; rd_addr_b = 5'd5;
        #1;
        chk("byp_x5_a", rd_data_a[63:32], 64'hDEADBEEF);
        chk("nobyp_x5_b", 64'(rd_data_b), 64'd0);
        tick();
        wr_en_a = '0; wr_en_b = '0;
        #1;
        chk("stored_x5_a", rd_data_a[63:32], 64'hDEADBEEF);
        chk("stored_x5_b", 64'(rd_data_b), 64'hDEADBEEF);

        // x0 writes: hardwired on A, ordinary on B
        wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd0}; wr_data_a = {32'd0, 32'hFFFFFFFF};
        rd_addr_a = {5'd0, 5'd0};
        wr_en_b = 1'b1; wr_addr_b = 5'd0; wr_data_b = 32'hFFFFFFFF; rd_addr_b = 5'd0;
        #1;
        chk("x0_byp_a", rd_data_a, 64'd0);
        chk("x0_same_b", 64'(rd_data_b), 64'd0);
        tick();
        wr_en_a = '0; wr_en_b = '0;
        #1;
        chk("x0_next_a", rd_data_a, 64'd0);
        chk("x0_next_b", 64'(rd_data_b), 64'hFFFFFFFF);

        // Same-address collision: port 1 wins
        wr_en_a = 2'b11; wr_addr_a = {5'd7, 5'd7}; wr_data_a = {32'h22222222, 32'h11111111};
        rd_addr_a = {5'd5, 5'd7};
        #1;
        chk("coll_byp", rd_data_a[31:0], 64'h22222222);
        chk("coll_other_port", rd_data_a[63:32], 64'hDEADBEEF);
        tick();
        wr_en_a = '0;
        rd_addr_a = {5'd7, 5'd7};
        #1;
        chk("coll_stored", rd_data_a, {32'h22222222, 32'h22222222});

        // Independent addresses on both ports
        wr_en_a = 2'b11; wr_addr_a = {5'd10, 5'd9}; wr_data_a = {32'h5A5A5A5A, 32'hA5A5A5A5};
        rd_addr_a = {5'd10, 5'd9};
        #1;
        chk("dual_byp", rd_data_a, {32'h5A5A5A5A, 32'hA5A5A5A5});
        tick();
        wr_en_a = '0;
        #1;
        chk("dual_stored", rd_data_a, {32'h5A5A5A5A, 32'hA5A5A5A5});

        // Clear request with a write in the same cycle, writes attempted throughout the sweep
        wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd3}; wr_data_a = {32'd0, 32'h0000ABCD};
        tick();
        wr_en_a = '0; rd_addr_a = {5'd4, 5'd3};
        #1;
        chk("x3_before_clear", rd_data_a[31:0], 64'h0000ABCD);
        clear_req_a = 1'b1;
        wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd4}; wr_data_a = {32'd0, 32'h00001234};
        tick();
        clear_req_a = 1'b0;
        chk("clear_ready_drop", 64'(ready_a), 64'd0);
        wr_en_a = 2'b11; wr_addr_a = {5'd3, 5'd3}; wr_data_a = {32'hFFFFFFFF, 32'hFFFFFFFF};
        rd_addr_a = {5'd3, 5'd3};
        #1;
        chk("notready_rd_zero", rd_data_a, 64'd0);
        na = -1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (ready_a) begin
                na = c;
                break;
            end
        end
        wr_en_a = '0;
        chk("clear_sweep_len", 64'(na), 64'd32);
        rd_addr_a = {5'd4, 5'd3};
        #1;
        chk("clear_x3_x4", rd_data_a, 64'd0);
        rd_addr_b = 5'd5;
        #1;
        chk("b_unaffected", 64'(rd_data_b), 64'hDEADBEEF);

        // Reset at sweep cycle 10; a clear_req during the new sweep must be ignored
        reset = 1'b1;
        #1;
        chk("rst_ready_a", 64'(ready_a), 64'd0);
        tick(); tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        chk("mid_sweep_ready", 64'(ready_a), 64'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(ready_a), 64'd0);
        tick(); tick();
        reset = 1'b0;
        wait_both(na, nb, 1'b1);
        chk("restart_len_a", 64'(na), 64'd32);
        chk("restart_len_b", 64'(nb), 64'd32);
        rd_addr_a = {5'd10, 5'd9};
        #1;
        chk("restart_cleared", rd_data_a, 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port integer register file, successor to the single-write/dual-read RV32I register file.
- Generalised in data width, register count, read-port count and write-port count.
- Adds optional write-to-read bypass and a post-reset clear sweep that zeroes every register one per cycle and raises `ready` when done.
- Sits between decode (read addresses) and writeback (write ports) of the TEJAS core; multi-cycle control waits for `ready` before the first fetch.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers; power of two, at least 2.
- NRD, 2, number of read ports, 1..4.
- NWR, 1, number of write ports, 1..2.
- BYPASS, 1: a read returns same-cycle write data for a matching address; 0: a read returns the stored (pre-write) value.
- ZERO_REG, 1: register 0 is hardwired to zero; 0: register 0 is an ordinary register.
- Localparam AW = $clog2(NREGS); not overridable.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- clear_req  in  1  one-cycle pulse; restarts the clear sweep.
- ready  out  1  high when the array is valid and accepting writes.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  packed write addresses; port k uses bits [k*AW +: AW].
- wr_data  in  NWR*XLEN  packed write data; port k uses bits [k*XLEN +: XLEN].
- rd_addr  in  NRD*AW  packed read addresses.
- rd_data  out  NRD*XLEN  packed read data; combinational from `rd_addr`.

Behaviour:
- Reset and clock
  - One clock; reset is asynchronous and active-high.
  - Reset asserted: state <= CLEAR, clr_idx <= 0, ready <= 0.
  - The array itself is not reset (RAM-friendly); it is zeroed only by the sweep.
  - Reset asserted mid-sweep restarts the sweep from index 0.
- State machine (2 states)
  - CLEAR: each cycle, regs[clr_idx] <= 0 and clr_idx <= clr_idx+1. When clr_idx == NREGS-1, go to READY on the next edge. Sweep takes exactly NREGS cycles after reset deassertion. `ready` goes high on the edge that writes the last entry.
  - READY: normal operation. `clear_req` == 1 sets state <= CLEAR, clr_idx <= 0 and ready <= 0 on the next edge; any write in that same cycle is still performed.
- While not ready
  - All `wr_en` are ignored.
  - All `rd_data` read 0.
  - `clear_req` is ignored; the sweep is already running.
- Writes (READY only)
  - Synchronous on the rising edge.
  - Writes to address 0 are dropped when ZERO_REG=1.
  - Two write ports with the same address in the same cycle: the highest-index port wins.
- Reads
  - Asynchronous.
  - Address 0 returns 0 when ZERO_REG=1, regardless of bypass.
  - BYPASS=1: if any enabled write port matches the read address, return that port's `wr_data` (highest-index match wins); otherwise return the array value.
  - BYPASS=0: always return the array value.
- Widths: addresses are exactly AW bits, so no out-of-range address exists. No arithmetic is performed on data.
- Latency: write-to-read is 1 cycle with BYPASS=0 and 0 cycles with BYPASS=1.

Decomposition:
- Shared package tejas_pkg holds XLEN_DEFAULT=32, NREGS_DEFAULT=32 and the state enum {RF_CLEAR, RF_READY}.
- One sub-module, rf_bypass_mux: per read port, it takes the array word, the write vectors and the address, and returns the selected word. It is instantiated NRD times via generate.
- Clear FSM and array stay in reg_file_mp.

Test Plan:
- Reset sweep
  - Stimulus: reset 1 for 3 cycles, then release; default params.
  - Response: ready == 0 for exactly 32 cycles, then 1; all 32 registers read 0x00000000.
- Basic write/read, BYPASS=1
  - Stimulus: write x5 = 0xDEADBEEF via port 0.
  - Response: rd_data port 1 with rd_addr=5 shows 0xDEADBEEF in the same cycle; with BYPASS=0 it shows 0 until the next cycle.
- x0 protection
  - Stimulus: write x0 = 0xFFFFFFFF.
  - Response: reads of address 0 return 0 in the same and following cycles, including the bypass path.
- Dual-write collision, NWR=2
  - Stimulus: port 0 writes x7 = 0x11111111 and port 1 writes x7 = 0x22222222 in the same cycle.
  - Response: the bypass read and the next-cycle read both return 0x22222222.
- Clear request
  - Stimulus: in READY with x3 = 0xABCD, pulse clear_req.
  - Response: ready drops next cycle; writes are ignored for 32 cycles; afterwards x3 == 0.
- Reset mid-sweep
  - Stimulus: assert reset at sweep cycle 10.
  - Response: ready stays 0; after release the sweep restarts and takes 32 full cycles before ready == 1.
